efect_report_tx: RTL and testbench
==================================

EFECT_REPORT_TX -- requirements
Module: efect_report_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal minimum 2.
REQ-002 Parameter NUM_EFECTS, default 6, width of the effect select vector.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 efect_i  input  6  effect select, one-hot: bit n means effect n is active.
REQ-006 send_i  input  1  single-cycle request to re-report the current effect.
REQ-007 tx_o  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 busy_o  output  1  high while a report is being serialized.
REQ-009 done_o  output  1  one-cycle pulse when a report completes.

Function
REQ-010 The block SHALL encode efect_i as an ASCII digit: 48 + index of the lowest set bit ('0'..'5'); all-zero SHALL encode as '0' (48); multi-hot SHALL use the lowest set bit.
REQ-011 A report event SHALL be send_i=1, or efect_i != efect_q, where efect_q is efect_i registered every cycle.
REQ-012 Any event sampled at edge k SHALL set a pending flag at edge k; pending SHALL clear on the edge that enters START.
REQ-013 FSM states: IDLE, START, DATA, STOP. IDLE with pending=1 SHALL enter START on the next edge, latching the encoded character of that cycle into the shift register.
REQ-014 START SHALL drive tx_o=0 for CLKS_PER_BIT cycles; DATA SHALL drive 8 bits LSB first, CLKS_PER_BIT cycles each; STOP SHALL drive tx_o=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-015 Latency: an event at edge k SHALL give tx_o low from edge k+1 when the block is IDLE.
REQ-016 A frame SHALL last exactly 10*CLKS_PER_BIT cycles; busy_o SHALL be high from START entry to STOP exit inclusive.
REQ-017 done_o SHALL pulse for one cycle on the edge leaving STOP.
REQ-018 Events during a frame SHALL coalesce into one pending report; that report SHALL carry the value of efect_i when its START is entered, not the value at event time.
REQ-019 An event in the last STOP cycle SHALL set pending; the next START SHALL follow after exactly one IDLE cycle.
REQ-020 The character in flight SHALL NOT change when efect_i changes mid-frame.
REQ-021 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-022 On rst_n=0: tx_o=1, busy_o=0, done_o=0, state=IDLE, pending=0, efect_q=0, counters=0, asynchronously.
REQ-023 Reset mid-frame SHALL abort the frame with tx_o high immediately; no resumption.
REQ-024 Because efect_q resets to 0, a nonzero efect_i after reset release SHALL produce one power-up report.

Configuration
REQ-025 Macro EFECT_REPORT_CRLF_EN defined: each report SHALL be three frames, digit, 0x0D, 0x0A, back to back with one IDLE cycle between frames; busy_o SHALL stay high across all three; done_o SHALL pulse only after the LF frame.
REQ-026 Macro undefined: each report SHALL be the single digit frame only.

Structure
REQ-027 Package efect_pkg SHALL hold ASCII_ZERO=48, ASCII_CR=8'h0D, ASCII_LF=8'h0A, NUM_EFECTS=6 and the FSM state enumeration.
REQ-028 Combinational sub-module efect_to_ascii (one-hot to ASCII, REQ-010) SHALL be instantiated once; the FSM, baud counter and shift register stay in efect_report_tx.

Verification (bench CLKS_PER_BIT=4)
REQ-029 Release reset with efect_i=6'b000100 -> one frame 0x32 ('2'): tx_o low from the cycle after release, 40 cycles, then done_o pulse.
REQ-030 IDLE, efect_i held 6'b000001, send_i pulse -> frame 0x30; bits LSB first 0,0,0,0,1,1,0,0, each exactly 4 cycles.
REQ-031 Mid-frame, change efect_i 000001->001000->100000 -> current frame completes unchanged; exactly one further frame 0x35 follows after one IDLE cycle.
REQ-032 efect_i=6'b000000 then 6'b011000 -> frames 0x30 then 0x33.
REQ-033 Drop rst_n at bit 5 of a frame -> tx_o=1, busy_o=0 the same cycle; no frame after release while efect_i is 0.
REQ-034 With EFECT_REPORT_CRLF_EN and efect_i=6'b010000 -> frames 0x34, 0x0D, 0x0A; busy_o continuously high for 122 cycles; single done_o pulse.

Source files
------------

// File: rtl/efect_pkg.sv
// Shared constants and FSM state type for the effect-report UART transmitter.
package efect_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'd48;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         NUM_EFECTS = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

endpackage

// File: rtl/efect_to_ascii.sv
// One-hot effect select to ASCII digit; lowest set bit wins, all-zero encodes '0'.
module efect_to_ascii #(
  parameter int NUM_EFECTS = efect_pkg::NUM_EFECTS
) (
  input  logic [NUM_EFECTS-1:0] efect_i,
  output logic [7:0]            ascii_o
);
  import efect_pkg::*;

  // Scan high to low so the lowest set bit is the last (winning) assignment.
  always_comb begin
    ascii_o = ASCII_ZERO;
    for (int i = NUM_EFECTS - 1; i >= 0; i--) begin
      if (efect_i[i]) ascii_o = ASCII_ZERO + 8'(i);
    end
  end

endmodule

// File: rtl/efect_report_tx.sv
// Reports the active effect as an ASCII digit over 8N1 UART on change or on send_i.
// Optional EFECT_REPORT_CRLF_EN appends CR and LF frames to every report.
module efect_report_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int NUM_EFECTS   = efect_pkg::NUM_EFECTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EFECTS-1:0] efect_i,
  input  logic                  send_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);
  import efect_pkg::*;

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  state_e                  state_q, state_d;
  logic [NUM_EFECTS-1:0]   efect_q, efect_d;
  logic                    pend_q, pend_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              bit_q, bit_d;
  logic [7:0]              shift_q, shift_d;
  logic                    done_q, done_d;

  logic [7:0] ascii;
  logic       evt, bit_end, start_new, stop_exit;
  logic       frm_act, frm_last;
  logic [7:0] frm_char;

  efect_to_ascii #(.NUM_EFECTS(NUM_EFECTS)) u_enc (
    .efect_i (efect_i),
    .ascii_o (ascii)
  );

`ifdef EFECT_REPORT_CRLF_EN
  // Frame index within a report: 0 digit, 1 CR, 2 LF. Nonzero keeps busy across gaps.
  logic [1:0] frm_q, frm_d;

  always_comb begin
    frm_d = frm_q;
    if (stop_exit) frm_d = frm_last ? 2'd0 : frm_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frm_q <= 2'd0;
    else        frm_q <= frm_d;
  end

  assign frm_act  = (frm_q != 2'd0);
  assign frm_last = (frm_q == 2'd2);
  assign frm_char = (frm_q == 2'd1) ? ASCII_CR : ASCII_LF;
`else
  assign frm_act  = 1'b0;
  assign frm_last = 1'b1;
  assign frm_char = ASCII_ZERO;
`endif

  assign evt     = send_i | (efect_i != efect_q);
  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    efect_d   = efect_i;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    start_new = 1'b0;
    stop_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (frm_act || pend_q) begin
          state_d   = ST_START;
          shift_d   = frm_act ? frm_char : ascii;
          start_new = ~frm_act;
        end
      end
      ST_START: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          state_d   = ST_IDLE;
          stop_exit = 1'b1;
          done_d    = frm_last;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Only a new report consumes pending; events during CR/LF frames stay queued.
    pend_d = start_new ? 1'b0 : (pend_q | evt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      efect_q <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      efect_q <= efect_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      ST_START: tx_o = 1'b0;
      ST_DATA:  tx_o = shift_q[0];
      default:  tx_o = 1'b1;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE) | frm_act;
  assign done_o = done_q;

endmodule

// File: tb/tb_efect_report_tx.sv
// Randomized and directed bench for efect_report_tx against a timeline-based reference model.
module tb_efect_report_tx;
  localparam int CPB  = 4;
  localparam int NE   = 6;
  localparam int FLEN = 10 * CPB;
`ifdef EFECT_REPORT_CRLF_EN
  localparam int NFR  = 3;
`else
  localparam int NFR  = 1;
`endif
  localparam int BUSYLEN = NFR * FLEN + NFR - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] efect_i = '0;
  logic          send_i = 1'b0;
  logic          tx_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: position inside the current frame (-1 when the line is idle).
  int            m_pos = -1;
  int            m_nf  = 0;
  logic [7:0]    m_ch  = 8'd0;
  bit            m_pend = 1'b0;
  bit            m_done = 1'b0;
  logic [NE-1:0] m_efq = '0;
  logic          exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

  logic cap[$];
  logic bcap[$];
  logic dcap[$];

  efect_report_tx #(.CLKS_PER_BIT(CPB), .NUM_EFECTS(NE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .efect_i (efect_i),
    .send_i  (send_i),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_char(input logic [NE-1:0] e);
    for (int i = 0; i < NE; i++) if (e[i]) return 8'd48 + 8'(i);
    return 8'd48;
  endfunction

  function automatic logic [7:0] frame_char(input int nf, input logic [NE-1:0] e);
    if (nf == 1) return 8'h0D;
    if (nf == 2) return 8'h0A;
    return ref_char(e);
  endfunction

  task automatic model_reset();
    m_pos = -1; m_nf = 0; m_pend = 1'b0; m_done = 1'b0; m_efq = '0;
    exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present before that edge.
  task automatic model_edge();
    bit evt;
    evt    = send_i || (efect_i != m_efq);
    m_efq  = efect_i;
    m_done = 1'b0;
    if (m_pos < 0) begin
      if (m_nf > 0) begin
        m_pos = 0; m_ch = frame_char(m_nf, efect_i); m_pend = m_pend | evt;
      end else if (m_pend) begin
        m_pos = 0; m_ch = frame_char(0, efect_i); m_pend = 1'b0;
      end else begin
        m_pend = evt;
      end
    end else begin
      m_pend = m_pend | evt;
      m_pos++;
      if (m_pos == FLEN) begin
        m_pos = -1;
        if (m_nf == NFR - 1) begin m_nf = 0; m_done = 1'b1; end
        else m_nf++;
      end
    end
    if (m_pos < 0)              exp_tx = 1'b1;
    else if (m_pos < CPB)       exp_tx = 1'b0;
    else if (m_pos < 9 * CPB)   exp_tx = m_ch[(m_pos - CPB) / CPB];
    else                        exp_tx = 1'b1;
    exp_busy = (m_pos >= 0) || (m_nf > 0);
    exp_done = m_done;
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    cap.push_back(tx_o);
    bcap.push_back(busy_o);
    dcap.push_back(done_o);
  endtask

  task automatic clear_cap();
    cap.delete(); bcap.delete(); dcap.delete();
  endtask

  function automatic int busy_rise(input int k);
    int n = 0;
    for (int i = 0; i < bcap.size(); i++) begin
      if (bcap[i] && (i == 0 || !bcap[i-1])) begin
        if (n == k) return i;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic int count_ones(input int which);
    int n = 0;
    for (int i = 0; i < bcap.size(); i++) n += (which == 0) ? int'(bcap[i]) : int'(dcap[i]);
    return n;
  endfunction

  function automatic logic [7:0] cap_char(input int s);
    logic [7:0] c = 8'hxx;
    if (s < 0 || s + 9 * CPB >= cap.size()) return c;
    for (int b = 0; b < 8; b++) c[b] = cap[s + CPB * (b + 1) + CPB / 2];
    return c;
  endfunction

  task automatic test_reset();
    efect_i = 6'b000100;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (tx_o !== 1'b1)   begin bad++; $display("FAIL reset_tx got %b want 1", tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done_o); end
  endtask

  task automatic test_powerup();
    clear_cap();
    rst_n = 1'b1;
    for (int i = 0; i < BUSYLEN + 6; i++) begin
      cycle();
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL powerup cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    total++; if (busy_rise(0) !== 1) begin bad++; $display("FAIL powerup_latency got %0d want 1", busy_rise(0)); end
    total++; if (cap_char(busy_rise(0)) !== 8'h32) begin bad++; $display("FAIL powerup_char got %h want 32", cap_char(busy_rise(0))); end
    total++; if (count_ones(0) != BUSYLEN) begin bad++; $display("FAIL powerup_busylen got %0d want %0d", count_ones(0), BUSYLEN); end
    total++; if (count_ones(1) != 1) begin bad++; $display("FAIL powerup_done got %0d want 1", count_ones(1)); end
  endtask

  task automatic test_send();
    logic [7:0] want = 8'h30;
    int s, nbad;
    efect_i = 6'b000001;
    for (int i = 0; i < BUSYLEN + 4; i++) begin
      cycle();
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL send_pre cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    clear_cap();
    send_i = 1'b1;
    for (int i = 0; i < BUSYLEN + 4; i++) begin
      cycle();
      send_i = 1'b0;
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL send cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    s = busy_rise(0);
    total++; if (s !== 1) begin bad++; $display("FAIL send_latency got %0d want 1", s); end
    nbad = 0;
    if (s >= 0) begin
      for (int b = 0; b < 8; b++)
        for (int k = 0; k < CPB; k++)
          if (cap[s + CPB * (b + 1) + k] !== want[b]) nbad++;
    end else nbad = 99;
    total++; if (nbad != 0) begin bad++; $display("FAIL send_bits got %0d wrong samples want 0", nbad); end
    total++; if (cap_char(s) !== want) begin bad++; $display("FAIL send_char got %h want %h", cap_char(s), want); end
  endtask

  task automatic test_midframe();
    int r0, r1;
    clear_cap();
    send_i = 1'b1;
    for (int i = 0; i < 2 * BUSYLEN + 8; i++) begin
      if (i == 10) efect_i = 6'b001000;
      if (i == 20) efect_i = 6'b100000;
      cycle();
      send_i = 1'b0;
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL midframe cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    r0 = busy_rise(0); r1 = busy_rise(1);
    total++; if (cap_char(r0) !== 8'h30) begin bad++; $display("FAIL midframe_first got %h want 30", cap_char(r0)); end
    total++; if (cap_char(r1) !== 8'h35) begin bad++; $display("FAIL midframe_second got %h want 35", cap_char(r1)); end
    total++; if (r1 - r0 != BUSYLEN + 1) begin bad++; $display("FAIL midframe_gap got %0d want %0d", r1 - r0, BUSYLEN + 1); end
    total++; if (busy_rise(2) != -1) begin bad++; $display("FAIL midframe_extra got %0d want -1", busy_rise(2)); end
  endtask

  task automatic test_zero_then();
    clear_cap();
    efect_i = 6'b000000;
    for (int i = 0; i < 2 * BUSYLEN + 10; i++) begin
      if (i == BUSYLEN + 4) efect_i = 6'b011000;
      cycle();
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL zero_then cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    total++; if (cap_char(busy_rise(0)) !== 8'h30) begin bad++; $display("FAIL zero_char got %h want 30", cap_char(busy_rise(0))); end
    total++; if (cap_char(busy_rise(1)) !== 8'h33) begin bad++; $display("FAIL multihot_char got %h want 33", cap_char(busy_rise(1))); end
  endtask

  task automatic test_back_to_back();
    bit fired = 1'b0;
    int r0, r1;
    clear_cap();
    send_i = 1'b1;
    for (int i = 0; i < 2 * BUSYLEN + 8; i++) begin
      if (!fired && m_pos == FLEN - 1 && m_nf == NFR - 1) begin send_i = 1'b1; fired = 1'b1; end
      cycle();
      send_i = 1'b0;
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL b2b cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    r0 = busy_rise(0); r1 = busy_rise(1);
    total++; if (r0 < 0 || r1 - r0 != BUSYLEN + 1) begin bad++; $display("FAIL b2b_gap got %0d want %0d", r1 - r0, BUSYLEN + 1); end
  endtask

  task automatic test_reset_midframe();
    int guard = 0;
    send_i = 1'b1;
    while (m_pos != 5 * CPB + 1 && guard < 4 * BUSYLEN) begin
      cycle();
      send_i = 1'b0;
      guard++;
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL rstmid_pre cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    total++; if (m_pos != 5 * CPB + 1) begin bad++; $display("FAIL rstmid_reach got pos %0d want %0d", m_pos, 5 * CPB + 1); end
    rst_n = 1'b0;
    #1;
    total++; if (tx_o !== 1'b1)   begin bad++; $display("FAIL rstmid_tx got %b want 1", tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    model_reset();
    efect_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_cap();
    for (int i = 0; i < 50; i++) begin
      cycle();
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL rstmid_post cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    total++; if (count_ones(0) != 0) begin bad++; $display("FAIL rstmid_noframe got %0d busy cycles want 0", count_ones(0)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600 + 2 * BUSYLEN; i++) begin
      if (i < 600) begin
        send_i = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 14) == 0) efect_i = NE'($urandom_range(0, 63));
      end
      cycle();
      send_i = 1'b0;
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL random cyc=%0d efect=%b got tx/busy/done=%b%b%b want %b%b%b", cyc, efect_i, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL random_quiesce got busy %b want 0", busy_o); end
  endtask

`ifdef EFECT_REPORT_CRLF_EN
  task automatic test_crlf();
    int r0;
    clear_cap();
    efect_i = 6'b010000;
    for (int i = 0; i < BUSYLEN + 8; i++) begin
      cycle();
      total++;
      if ({tx_o, busy_o, done_o} !== {exp_tx, exp_busy, exp_done}) begin
        bad++; $display("FAIL crlf cyc=%0d got tx/busy/done=%b%b%b want %b%b%b", cyc, tx_o, busy_o, done_o, exp_tx, exp_busy, exp_done);
      end
    end
    r0 = busy_rise(0);
    total++; if (cap_char(r0) !== 8'h34) begin bad++; $display("FAIL crlf_digit got %h want 34", cap_char(r0)); end
    total++; if (cap_char(r0 + FLEN + 1) !== 8'h0D) begin bad++; $display("FAIL crlf_cr got %h want 0d", cap_char(r0 + FLEN + 1)); end
    total++; if (cap_char(r0 + 2 * FLEN + 2) !== 8'h0A) begin bad++; $display("FAIL crlf_lf got %h want 0a", cap_char(r0 + 2 * FLEN + 2)); end
    total++; if (count_ones(0) != 122 || busy_rise(1) != -1) begin bad++; $display("FAIL crlf_busy got %0d cycles want 122 contiguous", count_ones(0)); end
    total++; if (count_ones(1) != 1) begin bad++; $display("FAIL crlf_done got %0d want 1", count_ones(1)); end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_send();
    test_midframe();
    test_zero_then();
    test_back_to_back();
    test_reset_midframe();
    test_random();
`ifdef EFECT_REPORT_CRLF_EN
    test_crlf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
